// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with flush, stall and load-use bubble insertion
// Optional bubble counter enabled by ID_EX_BUBBLE_CNT_EN
module id_ex_pipeline_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_valid,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic              in_ctrl_regwrt,
    input  logic              in_ctrl_memrd,
    input  logic              in_ctrl_memwrt,
    input  logic              in_ctrl_alusrc,
    input  logic [2:0]        in_ctrl_aluop,
    input  logic              in_ctrl_memtoreg,
    input  logic              in_ctrl_branch,
    input  logic              in_ctrl_btype,
    input  logic              in_ctrl_jump,
    input  logic [REG_AW-1:0] in_rs_idx,
    input  logic [REG_AW-1:0] in_rt_idx,
    input  logic [REG_AW-1:0] in_rd_idx,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    output logic              out_ctrl_regwrt,
    output logic              out_ctrl_memrd,
    output logic              out_ctrl_memwrt,
    output logic              out_ctrl_alusrc,
    output logic [2:0]        out_ctrl_aluop,
    output logic              out_ctrl_memtoreg,
    output logic              out_ctrl_branch,
    output logic              out_ctrl_btype,
    output logic              out_ctrl_jump,
    output logic [REG_AW-1:0] out_rd_idx,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0]  out_bubble_cnt,
`endif
    output logic              out_hazard
);

    logic do_bubble;
    logic do_load;

    // A load in EX whose destination feeds the ID instruction must be separated by one bubble
    assign out_hazard = out_valid & out_ctrl_memrd & in_valid
                      & ((out_rd_idx == in_rs_idx) | (out_rd_idx == in_rt_idx));

    always_comb begin
        do_bubble = 1'b0;
        do_load   = 1'b0;
        if (in_flush) begin
            do_bubble = 1'b1;
        end else if (!in_stall) begin
            if (out_hazard) begin
                do_bubble = 1'b1;
            end else begin
                do_load = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst || do_bubble) begin
            out_valid         <= 1'b0;
            out_ctrl_regwrt   <= 1'b0;
            out_ctrl_memrd    <= 1'b0;
            out_ctrl_memwrt   <= 1'b0;
            out_ctrl_alusrc   <= 1'b0;
            out_ctrl_aluop    <= 3'b000;
            out_ctrl_memtoreg <= 1'b0;
            out_ctrl_branch   <= 1'b0;
            out_ctrl_btype    <= 1'b0;
            out_ctrl_jump     <= 1'b0;
            out_rd_idx        <= '0;
            out_rs_val        <= '0;
            out_rt_val        <= '0;
            out_imm           <= '0;
            out_pc            <= '0;
        end else if (do_load) begin
            // Control is gated by valid so an empty ID slot can never write state
            out_valid         <= in_valid;
            out_ctrl_regwrt   <= in_ctrl_regwrt & in_valid;
            out_ctrl_memrd    <= in_ctrl_memrd & in_valid;
            out_ctrl_memwrt   <= in_ctrl_memwrt & in_valid;
            out_ctrl_alusrc   <= in_ctrl_alusrc & in_valid;
            out_ctrl_aluop    <= in_ctrl_aluop & {3{in_valid}};
            out_ctrl_memtoreg <= in_ctrl_memtoreg & in_valid;
            out_ctrl_branch   <= in_ctrl_branch & in_valid;
            out_ctrl_btype    <= in_ctrl_btype & in_valid;
            out_ctrl_jump     <= in_ctrl_jump & in_valid;
            out_rd_idx        <= in_rd_idx;
            out_rs_val        <= in_rs_val;
            out_rt_val        <= in_rt_val;
            out_imm           <= in_imm;
            out_pc            <= in_pc;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_bubble_cnt <= '0;
        end else if (do_bubble && (out_bubble_cnt != {CNT_W{1'b1}})) begin
            out_bubble_cnt <= out_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule
